// File: rtl/sd_route_pkg.sv
// Shared types and default constants for the SD card route controller.
package sd_route_pkg;

   localparam int DEF_ACT_TIMEOUT = 1000000;
   localparam int DEF_IDLE_CYCLES = 16;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } route_state_t;

endpackage

// File: rtl/sd_act_timer.sv
// SPI activity timer: restarts on any mosi/miso change, saturates at ACT_TIMEOUT.
module sd_act_timer
   import sd_route_pkg::*;
#(
   parameter int ACT_TIMEOUT = DEF_ACT_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic mosi,
   input  logic miso,
   output logic act
);

   localparam int CW = $clog2(ACT_TIMEOUT + 1);
   localparam logic [CW-1:0] C_MAX = CW'(ACT_TIMEOUT);

   logic          r_mosi_q;
   logic          r_miso_q;
   logic [CW-1:0] r_cnt;
   logic          w_chg;

   assign w_chg = (mosi != r_mosi_q) || (miso != r_miso_q);

   // Edge history and saturating idle-time counter; reset value reads as inactive.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mosi_q <= 1'b0;
         r_miso_q <= 1'b0;
         r_cnt    <= C_MAX;
      end else begin
         r_mosi_q <= mosi;
         r_miso_q <= miso;
         if (w_chg)
            r_cnt <= '0;
         else if (r_cnt != C_MAX)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign act = (r_cnt < C_MAX);

endmodule

// File: rtl/sd_route_ctrl.sv
// Routes the core's SPI master to either the physical or the virtual SD card,
// switching only once the bus has been idle (cs high) long enough.
//
// state     | meaning
// ST_RUN    | bus routed to cur_sel, watching for a route request
// ST_DRAIN  | request pending, counting consecutive cs-high cycles
// ST_SWITCH | one cycle with both cards deselected, cur_sel takes req_sel
module sd_route_ctrl
   import sd_route_pkg::*;
#(
   parameter int ACT_TIMEOUT = DEF_ACT_TIMEOUT,
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic img_mounted,
   input  logic img_nz,
   input  logic spi_ck,
   input  logic spi_cs,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic phy_ck,
   output logic phy_cs,
   output logic phy_mosi,
   input  logic phy_miso,
   output logic vsd_ck,
   output logic vsd_cs,
   output logic vsd_mosi,
   input  logic vsd_miso,
   output logic vsd_sel,
   output logic led_vsd,
   output logic led_phy
);

   localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

   route_state_t  r_state;
   logic          r_cur_sel;
   logic          r_req_sel;
   logic [IW-1:0] r_idle;
   logic          r_led_vsd;
   logic          r_led_phy;

   logic [IW:0]   w_idle_nxt;
   logic          w_idle_done;
   logic          w_route_en;
   logic          w_act;

   assign w_idle_nxt  = {1'b0, r_idle} + {{IW{1'b0}}, 1'b1};
   assign w_idle_done = (w_idle_nxt >= {1'b0, IDLE_MAX});
   assign w_route_en  = (r_state != ST_SWITCH);

   // Route-selection FSM; a pending switch waits for IDLE_CYCLES consecutive cs-high cycles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_RUN;
         r_cur_sel <= 1'b0;
         r_req_sel <= 1'b0;
         r_idle    <= '0;
      end else begin
         if (img_mounted)
            r_req_sel <= img_nz;
         case (r_state)
            ST_RUN: begin
               r_idle <= '0;
               if (r_req_sel != r_cur_sel)
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (r_req_sel == r_cur_sel) begin
                  r_state <= ST_RUN;
                  r_idle  <= '0;
               end else if (spi_cs) begin
                  if (w_idle_done) begin
                     r_state <= ST_SWITCH;
                     r_idle  <= '0;
                  end else if (r_idle != IDLE_MAX) begin
                     r_idle <= w_idle_nxt[IW-1:0];
                  end
               end else begin
                  r_idle <= '0;
               end
            end
            ST_SWITCH: begin
               r_cur_sel <= r_req_sel;
               r_state   <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   // Activity LEDs follow the currently selected card.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_led_vsd <= 1'b0;
         r_led_phy <= 1'b0;
      end else begin
         r_led_vsd <= r_cur_sel & w_act;
         r_led_phy <= ~r_cur_sel & w_act;
      end
   end

   // Zero-latency bus mux; deselected cards see cs=1, ck=0, mosi=0.
   always_comb begin
      phy_ck   = 1'b0;
      phy_cs   = 1'b1;
      phy_mosi = 1'b0;
      vsd_ck   = 1'b0;
      vsd_cs   = 1'b1;
      vsd_mosi = 1'b0;
      spi_miso = 1'b1;
      if (w_route_en) begin
         if (r_cur_sel) begin
            vsd_ck   = spi_ck;
            vsd_cs   = spi_cs;
            vsd_mosi = spi_mosi;
            spi_miso = vsd_miso;
         end else begin
            phy_ck   = spi_ck;
            phy_cs   = spi_cs;
            phy_mosi = spi_mosi;
            spi_miso = phy_miso;
         end
      end
   end

   sd_act_timer #(
      .ACT_TIMEOUT (ACT_TIMEOUT)
   ) u_act_timer (
      .clock (clock),
      .reset (reset),
      .mosi  (spi_mosi),
      .miso  (spi_miso),
      .act   (w_act)
   );

   assign vsd_sel = r_cur_sel;
   assign led_vsd = r_led_vsd;
   assign led_phy = r_led_phy;

endmodule

// File: tb/tb_sd_route_ctrl.sv
// Scoreboard bench for sd_route_ctrl with a cycle-level behavioural model.
module tb_sd_route_ctrl;

   localparam int T_ACT  = 100;
   localparam int N_IDLE = 16;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic img_mounted = 1'b0, img_nz = 1'b0;
   logic spi_ck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
   logic phy_miso = 1'b0, vsd_miso = 1'b0;
   logic spi_miso, phy_ck, phy_cs, phy_mosi, vsd_ck, vsd_cs, vsd_mosi;
   logic vsd_sel, led_vsd, led_phy;

   always #5 clock = ~clock;

   sd_route_ctrl #(
      .ACT_TIMEOUT (T_ACT),
      .IDLE_CYCLES (N_IDLE)
   ) dut (
      .clock (clock), .reset (reset),
      .img_mounted (img_mounted), .img_nz (img_nz),
      .spi_ck (spi_ck), .spi_cs (spi_cs), .spi_mosi (spi_mosi), .spi_miso (spi_miso),
      .phy_ck (phy_ck), .phy_cs (phy_cs), .phy_mosi (phy_mosi), .phy_miso (phy_miso),
      .vsd_ck (vsd_ck), .vsd_cs (vsd_cs), .vsd_mosi (vsd_mosi), .vsd_miso (vsd_miso),
      .vsd_sel (vsd_sel), .led_vsd (led_vsd), .led_phy (led_phy)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [9:0] sb[$];
   string names [0:9] = '{"led_phy", "led_vsd", "vsd_sel", "vsd_mosi", "vsd_cs",
                          "vsd_ck", "phy_mosi", "phy_cs", "phy_ck", "spi_miso"};

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit     m_cur, m_req, m_drain, m_sw, m_pmosi, m_pmiso, m_lv, m_lp, m_exp_miso;
   int     m_idle;
   longint m_cyc = 0;
   longint m_last;

   function automatic void model_reset();
      m_cur = 0; m_req = 0; m_drain = 0; m_sw = 0; m_idle = 0;
      m_pmosi = 0; m_pmiso = 0; m_lv = 0; m_lp = 0;
      m_last = m_cyc - T_ACT - 10;
   endfunction

   function automatic logic [9:0] model_outputs();
      bit pc, pcs, pm, vc, vcs, vm, sm;
      pc = 0; pcs = 1; pm = 0; vc = 0; vcs = 1; vm = 0; sm = 1;
      if (!m_sw) begin
         if (m_cur) begin
            vc = spi_ck; vcs = spi_cs; vm = spi_mosi; sm = vsd_miso;
         end else begin
            pc = spi_ck; pcs = spi_cs; pm = spi_mosi; sm = phy_miso;
         end
      end
      return {sm, pc, pcs, pm, vc, vcs, vm, m_cur, m_lv, m_lp};
   endfunction

   function automatic void model_step();
      bit act_now, old_req;
      act_now = (m_cyc - m_last) < T_ACT;
      if (spi_mosi != m_pmosi || m_exp_miso != m_pmiso)
         m_last = m_cyc + 1;
      m_lv = m_cur && act_now;
      m_lp = !m_cur && act_now;
      old_req = m_req;
      if (img_mounted) m_req = img_nz;
      if (m_sw) begin
         m_cur = old_req;
         m_sw  = 0;
      end else if (m_drain) begin
         if (old_req == m_cur) m_drain = 0;
         else if (spi_cs) begin
            m_idle++;
            if (m_idle >= N_IDLE) begin m_sw = 1; m_drain = 0; end
         end else m_idle = 0;
      end else if (old_req != m_cur) begin
         m_drain = 1;
         m_idle  = 0;
      end
      m_pmosi = spi_mosi;
      m_pmiso = m_exp_miso;
      m_cyc++;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic bit rb();
      return bit'($urandom & 1);
   endfunction

   task automatic cyc(input bit mnt, input bit nz, input bit ck, input bit cs, input bit mosi,
                      input bit pm, input bit vm, output bit o_vsel, output bit o_smiso,
                      output bit o_lp);
      logic [9:0] e;
      @(negedge clock);
      img_mounted = mnt; img_nz = nz; spi_ck = ck; spi_cs = cs; spi_mosi = mosi;
      phy_miso = pm; vsd_miso = vm;
      #1;
      e = model_outputs();
      m_exp_miso = e[9];
      sb.push_back(e);
      o_vsel = vsd_sel; o_smiso = spi_miso; o_lp = led_phy;
      @(posedge clock);
      model_step();
   endtask

   task automatic rst_pulse();
      @(negedge clock);
      #3 reset = 1'b0;
      model_reset();
      #1;
      chk("vsd_sel_in_reset", vsd_sel, 0);
      chk("vsd_cs_in_reset", vsd_cs, 1);
      repeat (2) @(posedge clock);
      #2 reset = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [9:0] e, a;
      forever begin
         wait (sb.size() != 0);
         #1;
         e = sb.pop_front();
         a = {spi_miso, phy_ck, phy_cs, phy_mosi, vsd_ck, vsd_cs, vsd_mosi,
              vsd_sel, led_vsd, led_phy};
         for (int b = 0; b < 10; b++) chk(names[b], int'(a[b]), int'(e[b]));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // ---------------- directed + random sequences ----------------
   initial begin
      bit ov, os, ol, r_cs, r_mosi, r_pm, r_vm;
      int first, cnt, cnt2;
      model_reset();
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;

      // Out of reset: physical route active.
      repeat (10) cyc(0, 0, rb(), rb(), rb(), rb(), rb(), ov, os, ol);
      cyc(0, 0, 1, 0, 1, 0, 0, ov, os, ol);
      chk("vsd_sel_after_reset", vsd_sel, 0);
      chk("phy_cs_follows", phy_cs, 0);
      chk("phy_ck_follows", phy_ck, 1);
      chk("vsd_cs_idle", vsd_cs, 1);
      chk("vsd_ck_idle", vsd_ck, 0);

      // Mount, bus busy 40 cycles, then idle: switch after 16 high cycles.
      cyc(1, 1, 0, 0, 0, 0, 0, ov, os, ol);
      cnt = 0;
      repeat (40) begin
         cyc(0, 0, rb(), 0, rb(), rb(), rb(), ov, os, ol);
         cnt += int'(ov);
      end
      chk("no_switch_while_busy", cnt, 0);
      first = -1;
      for (int i = 0; i < 30; i++) begin
         cyc(0, 0, rb(), 1, rb(), rb(), rb(), ov, os, ol);
         if (ov && first < 0) first = i;
      end
      chk("switch_to_vsd_latency", first, 17);

      // Idle run broken after 10 cycles: count restarts.
      cyc(1, 0, 0, 0, 0, 0, 0, ov, os, ol);
      repeat (3)  cyc(0, 0, rb(), 0, rb(), rb(), rb(), ov, os, ol);
      repeat (10) cyc(0, 0, rb(), 1, rb(), rb(), rb(), ov, os, ol);
      cyc(0, 0, rb(), 0, rb(), rb(), rb(), ov, os, ol);
      first = -1;
      for (int i = 0; i < 30; i++) begin
         cyc(0, 0, rb(), 1, rb(), rb(), rb(), ov, os, ol);
         if (!ov && first < 0) first = i;
      end
      chk("switch_to_phy_after_restart", first, 17);

      // Request withdrawn during DRAIN: no SWITCH cycle.
      cyc(1, 1, 0, 0, 0, 0, 0, ov, os, ol);
      repeat (5) cyc(0, 0, rb(), 0, rb(), 0, rb(), ov, os, ol);
      cyc(1, 0, 0, 0, 0, 0, 0, ov, os, ol);
      cnt = 0; cnt2 = 0;
      repeat (30) begin
         cyc(0, 0, rb(), 1, rb(), 0, rb(), ov, os, ol);
         cnt += int'(ov); cnt2 += int'(os);
      end
      chk("withdrawn_vsd_sel", cnt, 0);
      chk("withdrawn_switch_cycles", cnt2, 0);

      // Activity window: one toggle -> 100 cycles, second toggle at 50 -> 150.
      repeat (110) cyc(0, 0, rb(), rb(), 0, 0, rb(), ov, os, ol);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         cyc(0, 0, rb(), rb(), 1, 0, rb(), ov, os, ol);
         cnt += int'(ol);
      end
      chk("led_window_single", cnt, 100);
      repeat (110) cyc(0, 0, rb(), rb(), 1, 0, rb(), ov, os, ol);
      cnt = 0;
      for (int i = 0; i < 250; i++) begin
         cyc(0, 0, rb(), rb(), (i >= 50), 0, rb(), ov, os, ol);
         cnt += int'(ol);
      end
      chk("led_window_extended", cnt, 150);

      // Reset mid-DRAIN drops the pending switch.
      cyc(1, 1, 0, 0, 0, 0, 0, ov, os, ol);
      repeat (5) cyc(0, 0, rb(), 0, rb(), rb(), rb(), ov, os, ol);
      rst_pulse();
      cnt = 0;
      repeat (30) begin
         cyc(0, 0, rb(), 1, rb(), rb(), rb(), ov, os, ol);
         cnt += int'(ov);
      end
      chk("reset_drops_switch", cnt, 0);

      // Randomised traffic with occasional mounts and resets.
      r_cs = 1; r_mosi = 0; r_pm = 0; r_vm = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0)  r_cs   = ~r_cs;
         if ($urandom_range(63) == 0) r_mosi = ~r_mosi;
         if ($urandom_range(63) == 0) r_pm   = ~r_pm;
         if ($urandom_range(63) == 0) r_vm   = ~r_vm;
         if ($urandom_range(699) == 0) rst_pulse();
         cyc(($urandom_range(15) == 0), rb(), rb(), r_cs, r_mosi, r_pm, r_vm, ov, os, ol);
      end

      @(negedge clock);
      #5;
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
